// File: rtl/dadda_mul16_seq_pkg.sv
// Shared types for the sequential 16x16 multiplier built around an external 8x8 Dadda array.
package dadda_pkg;

   localparam int N = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [1:0] pass_t;

endpackage

// File: rtl/dadda_mul16_seq.sv
// Four-pass 2N x 2N multiply sequencer driving one shared external N x N multiplier.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
//
// state | meaning
// IDLE  | ready for a request, multiplier inputs quiet
// MUL   | passes 0..3, one partial product accumulated per cycle
// DONE  | result held on out_p until out_ready
module dadda_mul16_seq
   import dadda_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_a,
   input  logic [2*N-1:0] in_b,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   input  logic [2*N-1:0] mul_p,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*N-1:0] out_p,
   output logic           busy
);

   state_t         state, state_nxt;
   pass_t          pass;
   logic [2*N-1:0] a_r, b_r;
   logic [2*N-1:0] a_in, b_in;
   logic [4*N-1:0] acc, acc_nxt, acc_fin;
   logic [5:0]     shamt;
   logic           accept, final_pass;

`ifdef MUL_SIGNED_EN
   logic neg;
   // -2^(2N-1) negates to itself, which is already the correct unsigned magnitude
   assign a_in    = in_a[2*N-1] ? -in_a : in_a;
   assign b_in    = in_b[2*N-1] ? -in_b : in_b;
   assign acc_fin = neg ? -acc_nxt : acc_nxt;
`else
   assign a_in    = in_a;
   assign b_in    = in_b;
   assign acc_fin = acc_nxt;
`endif

   always_comb begin
      unique case (pass)
         2'd0:    shamt = 6'd0;
         2'd3:    shamt = 6'(2*N);
         default: shamt = 6'(N);
      endcase
   end

   assign acc_nxt = acc + ({{(2*N){1'b0}}, mul_p} << shamt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      mul_a      = '0;
      mul_b      = '0;
      accept     = 1'b0;
      final_pass = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL: begin
            mul_a = pass[0] ? a_r[2*N-1:N] : a_r[N-1:0];
            mul_b = pass[1] ? b_r[2*N-1:N] : b_r[N-1:0];
            if (pass == 2'd3) begin
               final_pass = 1'b1;
               state_nxt  = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass      <= '0;
         acc       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         out_p     <= '0;
         out_valid <= 1'b0;
`ifdef MUL_SIGNED_EN
         neg       <= 1'b0;
`endif
      end else if (accept) begin
         a_r  <= a_in;
         b_r  <= b_in;
         acc  <= '0;
         pass <= '0;
`ifdef MUL_SIGNED_EN
         neg  <= in_a[2*N-1] ^ in_b[2*N-1];
`endif
      end else if (state == MUL) begin
         acc  <= acc_nxt;
         pass <= pass + 2'd1;
         if (final_pass) begin
            out_p     <= acc_fin;
            out_valid <= 1'b1;
         end
      end else if (state == DONE && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Randomised and directed bench for dadda_mul16_seq against a plain-arithmetic product model.
module tb_dadda_mul16_seq;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready;
   logic        in_ready, out_valid, busy;
   logic [15:0] in_a, in_b, mul_p;
   logic [7:0]  mul_a, mul_b;
   logic [31:0] out_p;

   int vectors = 0;
   int miscompares = 0;

   dadda_mul16_seq dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mul_p = 16'(mul_a) * 16'(mul_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
`else
      return 32'(a) * 32'(b);
`endif
   endfunction

   function automatic logic [15:0] mag(input logic [15:0] a);
`ifdef MUL_SIGNED_EN
      return a[15] ? 16'(-a) : a;
`else
      return a;
`endif
   endfunction

   // model: phase -1 idle, 0..3 multiply pass k, 4 holding result
   int          m_phase = -1;
   logic [15:0] m_a = '0, m_b = '0;
   logic [31:0] m_prod = '0, m_out_p = '0;
   logic        m_out_valid = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase     <= -1;
         m_out_valid <= 1'b0;
         m_out_p     <= '0;
      end else if (m_phase == -1) begin
         if (in_valid) begin
            m_a     <= mag(in_a);
            m_b     <= mag(in_b);
            m_prod  <= ref_prod(in_a, in_b);
            m_phase <= 0;
         end
      end else if (m_phase < 3) begin
         m_phase <= m_phase + 1;
      end else if (m_phase == 3) begin
         m_out_p     <= m_prod;
         m_out_valid <= 1'b1;
         m_phase     <= 4;
      end else if (out_ready) begin
         m_out_valid <= 1'b0;
         m_phase     <= -1;
      end
   end

   always @(posedge clk) begin
      logic [7:0] ea, eb;
      #1;
      if (rst_n) begin
         ea = 8'h00;
         eb = 8'h00;
         if (m_phase >= 0 && m_phase <= 3) begin
            ea = 8'(m_a >> (8 * (m_phase % 2)));
            eb = 8'(m_b >> (8 * (m_phase / 2)));
         end
         chk("in_ready",  in_ready,  m_phase == -1);
         chk("busy",      busy,      m_phase != -1);
         chk("out_valid", out_valid, m_out_valid);
         chk("out_p",     out_p,     m_out_p);
         chk("mul_a",     mul_a,     ea);
         chk("mul_b",     mul_b,     eb);
      end
   end

   // called at a negedge; returns at the negedge after the accept edge
   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      bit ok = 1'b0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
      end else begin
         chk("accept_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
   endtask

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (out_valid) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_t, cyc, n_acc;
      logic [31:0] hold;

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_p",     out_p,     32'h0);
      chk("rst_mul",       {mul_a, mul_b}, 16'h0);
      chk("rst_busy",      busy,      1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_out_p", out_p, 32'h0);

      // directed pass sequence and latency
      issue(16'h1234, 16'h5678);
      chk("seq_pass0", {mul_a, mul_b}, 16'h3478);
      @(negedge clk); chk("seq_pass1", {mul_a, mul_b}, 16'h1278);
      @(negedge clk); chk("seq_pass2", {mul_a, mul_b}, 16'h3456);
      @(negedge clk); chk("seq_pass3", {mul_a, mul_b}, 16'h1256);
      chk("lat_early", out_valid, 1'b0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1'b1);
      chk("p_1234x5678", out_p, 32'h06260060);
      chk("done_quiet", {mul_a, mul_b}, 16'h0);

`ifndef MUL_SIGNED_EN
      @(negedge clk);
      issue(16'hFFFF, 16'hFFFF);
      wait_valid();
      chk("p_ffffxffff", out_p, 32'hFFFE0001);
`endif
      @(negedge clk);
      issue(16'h0000, 16'hABCD);
      wait_valid();
      chk("p_0xabcd", out_p, 32'h0);

      // back-to-back with in_valid held and fresh operands every cycle
      @(negedge clk);
      in_valid = 1'b1;
      last_t = -1; n_acc = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         if (in_ready) begin
            if (last_t >= 0) chk("issue_interval", 32'(cyc - last_t), 32'd6);
            last_t = cyc;
            n_acc++;
         end
         in_a = 16'($urandom);
         in_b = 16'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("b2b_accepts_ge6", 32'(n_acc >= 6), 32'd1);

      // backpressure in DONE
      wait_idle();
      out_ready = 1'b0;
      issue(16'($urandom), 16'($urandom));
      wait_valid();
      hold = out_p;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_a = 16'($urandom);
         chk("bp_out_p", out_p, hold);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1'b0);
      chk("bp_release_ready", in_ready, 1'b1);

      // reset during pass 2
      issue(16'hBEEF, 16'h1357);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  in_ready,  1'b1);
      chk("mid_rst_busy",      busy,      1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_p",     out_p,     32'h0);
      chk("mid_rst_mul",       {mul_a, mul_b}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(16'd5, 16'd7);
      wait_valid();
      chk("post_rst_5x7", out_p, 32'd35);

`ifdef MUL_SIGNED_EN
      @(negedge clk);
      issue(16'hFFFD, 16'h0007);
      wait_valid();
      chk("s_m3x7", out_p, 32'hFFFFFFEB);
      @(negedge clk);
      issue(16'h8000, 16'h8000);
      wait_valid();
      chk("s_minxmin", out_p, 32'h40000000);
      @(negedge clk);
      issue(16'hFFFF, 16'hFFFF);
      wait_valid();
      chk("s_m1xm1", out_p, 32'h00000001);
`endif

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         in_valid  = ($urandom % 10) < 7;
         out_ready = ($urandom % 10) < 6;
         case ($urandom % 8)
            0:       in_a = 16'h0000;
            1:       in_a = 16'hFFFF;
            2:       in_a = 16'h8000;
            default: in_a = 16'($urandom);
         endcase
         case ($urandom % 8)
            0:       in_b = 16'h0000;
            1:       in_b = 16'hFFFF;
            2:       in_b = 16'h7FFF;
            default: in_b = 16'($urandom);
         endcase
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
